// File: rtl/csr_arb_pkg.sv
// Shared types for the CSR request arbiter and related arbiters.
package csr_arb_pkg;

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_WAIT_RSP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/csr_rr_pick.sv
// Combinational round-robin pick: lowest-offset valid requester starting at ptr.
module csr_rr_pick #(
  parameter int N   = 2,
  parameter int IdW = 1
) (
  input  logic [N-1:0]   valid,
  input  logic [IdW-1:0] ptr,
  output logic [IdW-1:0] gnt_id,
  output logic           gnt_vld
);

  localparam int PosW = (2 * N > 1) ? $clog2(2 * N) : 1;

  logic [2*N-1:0] dbl;

  assign dbl = {valid, valid};

  // Scan the doubled vector from ptr so the wrap-around needs no modulo logic.
  always_comb begin
    int pos;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (!gnt_vld && (pos < 2 * N) && dbl[PosW'(pos)]) begin
        gnt_vld = 1'b1;
        gnt_id  = (pos >= N) ? IdW'(pos - N) : IdW'(pos);
      end
    end
  end

endmodule

// File: rtl/csr_req_arbiter.sv
// Shares one CSR request/response port between NumReq requesters with
// round-robin arbitration and at most one read in flight.
module csr_req_arbiter
  import csr_arb_pkg::*;
#(
  parameter  int NumReq       = 2,
  parameter  int RegDataWidth = 32,
  parameter  int RegAddrWidth = 32,
  localparam int ReqIdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0][RegDataWidth-1:0]  req_data_i,
  input  logic [NumReq-1:0][RegAddrWidth-1:0]  req_addr_i,
  input  logic [NumReq-1:0]                    req_write_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  output logic [NumReq-1:0][RegDataWidth-1:0]  rsp_data_o,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [RegDataWidth-1:0]              csr_req_data_o,
  output logic [RegAddrWidth-1:0]              csr_req_addr_o,
  output logic                                 csr_req_write_o,
  output logic                                 csr_req_valid_o,
  input  logic                                 csr_req_ready_i,
  input  logic [RegDataWidth-1:0]              csr_rsp_data_i,
  input  logic                                 csr_rsp_valid_i,
  output logic                                 csr_rsp_ready_o,
  output logic [ReqIdWidth-1:0]                arb_owner_o,
  output logic                                 arb_rd_pending_o
);

  arb_state_e              state_q;
  logic [ReqIdWidth-1:0]   prio_ptr_q;
  logic                    lock_q;
  logic [ReqIdWidth-1:0]   lock_id_q;
  logic [ReqIdWidth-1:0]   owner_id_q;

  logic [ReqIdWidth-1:0]   pick_id;
  logic                    pick_vld;
  logic [ReqIdWidth-1:0]   grant;
  logic                    gnt_vld;
  logic                    req_active;
  logic [ReqIdWidth-1:0]   next_ptr;

  csr_rr_pick #(
    .N   (NumReq),
    .IdW (ReqIdWidth)
  ) u_pick (
    .valid   (req_valid_i),
    .ptr     (prio_ptr_q),
    .gnt_id  (pick_id),
    .gnt_vld (pick_vld)
  );

  // A stalled request keeps its grant; otherwise take the round-robin pick.
  always_comb begin
    grant      = lock_q ? lock_id_q : pick_id;
    gnt_vld    = lock_q | pick_vld;
    req_active = (state_q == ARB_IDLE) && gnt_vld;
    next_ptr   = (grant == ReqIdWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
  end

  // Request path: forward the granted requester to the CSR block.
  always_comb begin
    csr_req_data_o  = '0;
    csr_req_addr_o  = '0;
    csr_req_write_o = 1'b0;
    csr_req_valid_o = 1'b0;
    req_ready_o     = '0;
    if (req_active) begin
      csr_req_data_o     = req_data_i[grant];
      csr_req_addr_o     = req_addr_i[grant];
      csr_req_write_o    = req_write_i[grant];
      csr_req_valid_o    = 1'b1;
      req_ready_o[grant] = csr_req_ready_i;
    end
  end

  // Response path: only the read owner sees the CSR response.
  always_comb begin
    rsp_data_o      = '0;
    rsp_valid_o     = '0;
    csr_rsp_ready_o = 1'b0;
    if (state_q == ARB_WAIT_RSP) begin
      rsp_data_o[owner_id_q]  = csr_rsp_data_i;
      rsp_valid_o[owner_id_q] = csr_rsp_valid_i;
      csr_rsp_ready_o         = rsp_ready_i[owner_id_q];
    end
  end

  // Status: owner is the pending reader, else the current grant.
  always_comb begin
    arb_rd_pending_o = (state_q == ARB_WAIT_RSP);
    if (state_q == ARB_WAIT_RSP) begin
      arb_owner_o = owner_id_q;
    end else begin
      arb_owner_o = gnt_vld ? grant : '0;
    end
  end

  // Arbitration FSM: lock on stall, advance pointer on accept, wait for read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      prio_ptr_q <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      owner_id_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req_active) begin
            if (csr_req_ready_i) begin
              lock_q     <= 1'b0;
              prio_ptr_q <= next_ptr;
              if (!csr_req_write_o) begin
                owner_id_q <= grant;
                state_q    <= ARB_WAIT_RSP;
              end
            end else begin
              lock_q    <= 1'b1;
              lock_id_q <= grant;
            end
          end
        end
        ARB_WAIT_RSP: begin
          if (csr_rsp_valid_i && csr_rsp_ready_o) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
